// File: rtl/counter_mod.sv
// Modulo up/down counter with sync clear/load priority and a terminal-count flag.
// Latency: Q updates on the edge that samples the enables; Cout is combinational unless COUNTER_MOD_TC_REG_EN.
// Backpressure: none; Clk_En globally stalls the counter, Cnt_En gates counting only.
module counter_mod #(
    parameter int    lpm_width     = 16,
    parameter int    lpm_modulus   = 0,
    parameter string lpm_direction = "UNUSED"
) (
    input  logic                 Clock,
    input  logic                 Aclr_n,
    input  logic                 Clk_En,
    input  logic                 Cnt_En,
    input  logic                 UpDown,
    input  logic                 Sclr,
    input  logic                 Sload,
    input  logic [lpm_width-1:0] Data,
    output logic [lpm_width-1:0] Q,
    output logic                 Cout
);

    // Highest reachable count; modulus 0 means the full binary range.
    localparam logic [lpm_width-1:0] MAX_VAL =
        (lpm_modulus == 0) ? {lpm_width{1'b1}} : lpm_width'(lpm_modulus - 1);
    localparam bit FIX_UP   = (lpm_direction == "UP");
    localparam bit FIX_DOWN = (lpm_direction == "DOWN");

    logic                 count_up;
    logic                 at_term;
    logic                 tc_event;
    logic [lpm_width-1:0] load_val;
    logic [lpm_width-1:0] next_cnt;

    // Direction comes from the parameter when fixed, otherwise from UpDown on this edge.
    always_comb begin
        count_up = UpDown;
        if (FIX_UP) begin
            count_up = 1'b1;
        end else if (FIX_DOWN) begin
            count_up = 1'b0;
        end
    end

    // Terminal detection, wrap-aware next count, and load clamping.
    always_comb begin
        at_term  = count_up ? (Q == MAX_VAL) : (Q == '0);
        tc_event = Clk_En & Cnt_En & ~Sclr & ~Sload & at_term;
        load_val = (Data > MAX_VAL) ? MAX_VAL : Data;
        if (count_up) begin
            next_cnt = at_term ? '0 : Q + lpm_width'(1);
        end else begin
            next_cnt = at_term ? MAX_VAL : Q - lpm_width'(1);
        end
    end

    // Count register: clear beats load beats count, all gated by Clk_En.
    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            Q <= '0;
        end else if (Clk_En) begin
            if (Sclr) begin
                Q <= '0;
            end else if (Sload) begin
                Q <= load_val;
            end else if (Cnt_En) begin
                Q <= next_cnt;
            end
        end
    end

`ifdef COUNTER_MOD_TC_REG_EN
    logic cout_q;

    // Registered flag: high for the single cycle that starts at the wrap edge.
    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= tc_event;
        end
    end

    assign Cout = cout_q;
`else
    // Combinational flag, high in the cycle before the wrap; masked during reset
    // because Q=0 is terminal when counting down.
    assign Cout = tc_event & Aclr_n;
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboarded bench for counter_mod: four instances (mod-10 UNUSED/DOWN/UP, default 16-bit)
// share stimulus; a modulo-arithmetic model pushes expectations, a monitor pops and compares.
module tb_counter_mod;

    logic        clock = 1'b0;
    logic        aclr_n;
    logic        clk_en, cnt_en, up_down, sclr, sload;
    logic [15:0] data;
    logic [3:0]  q_a, q_b, q_d;
    logic [15:0] q_c;
    logic        c_a, c_b, c_c, c_d;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0][15:0] q;
        logic [3:0]       ev;
    } exp_t;

    exp_t   sb[$];
    longint st[4];
    longint modv[4] = '{10, 10, 65536, 10};
    int     dmode[4] = '{2, 0, 2, 1};  // 0 down, 1 up, 2 follows UpDown

    always #5 clock = ~clock;

    counter_mod #(.lpm_width(4), .lpm_modulus(10), .lpm_direction("UNUSED")) u_a (
        .Clock(clock), .Aclr_n(aclr_n), .Clk_En(clk_en), .Cnt_En(cnt_en), .UpDown(up_down),
        .Sclr(sclr), .Sload(sload), .Data(data[3:0]), .Q(q_a), .Cout(c_a));
    counter_mod #(.lpm_width(4), .lpm_modulus(10), .lpm_direction("DOWN")) u_b (
        .Clock(clock), .Aclr_n(aclr_n), .Clk_En(clk_en), .Cnt_En(cnt_en), .UpDown(up_down),
        .Sclr(sclr), .Sload(sload), .Data(data[3:0]), .Q(q_b), .Cout(c_b));
    counter_mod u_c (
        .Clock(clock), .Aclr_n(aclr_n), .Clk_En(clk_en), .Cnt_En(cnt_en), .UpDown(up_down),
        .Sclr(sclr), .Sload(sload), .Data(data), .Q(q_c), .Cout(c_c));
    counter_mod #(.lpm_width(4), .lpm_modulus(10), .lpm_direction("UP")) u_d (
        .Clock(clock), .Aclr_n(aclr_n), .Clk_En(clk_en), .Cnt_En(cnt_en), .UpDown(up_down),
        .Sclr(sclr), .Sload(sload), .Data(data[3:0]), .Q(q_d), .Cout(c_d));

    function automatic logic [15:0] q_of(input int i);
        case (i)
            0:       q_of = {12'h0, q_a};
            1:       q_of = {12'h0, q_b};
            2:       q_of = q_c;
            default: q_of = {12'h0, q_d};
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %h want %h", nm, i, $time, act, exp);
        end
    endtask

    // Model one clock edge for every instance and queue the expectation.
    task automatic model_push(input logic ce, input logic cn, input logic ud,
                              input logic sc, input logic sl, input logic [15:0] d);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            longint m  = modv[i];
            longint dv = (i == 2) ? longint'(d) : longint'(d[3:0]);
            bit     up = (dmode[i] == 2) ? ud : (dmode[i] == 1);
            bit     term = up ? (st[i] == m - 1) : (st[i] == 0);
            e.ev[i] = ce && cn && !sc && !sl && term;
            if (ce) begin
                if (sc)      st[i] = 0;
                else if (sl) st[i] = (dv >= m) ? m - 1 : dv;
                else if (cn) st[i] = up ? (st[i] + 1) % m : (st[i] + m - 1) % m;
            end
            e.q[i] = st[i][15:0];
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic ce, input logic cn, input logic ud,
                         input logic sc, input logic sl, input logic [15:0] d);
        clk_en = ce; cnt_en = cn; up_down = ud; sclr = sc; sload = sl; data = d;
    endtask

    task automatic cyc(input logic ce, input logic cn, input logic ud,
                       input logic sc, input logic sl, input logic [15:0] d);
        @(negedge clock);
        drive(ce, cn, ud, sc, sl, d);
        model_push(ce, cn, ud, sc, sl, d);
    endtask

    // Same as cyc, but with an asynchronous reset pulse between edges.
    task automatic cyc_rst(input logic ce, input logic cn, input logic ud,
                           input logic sc, input logic sl, input logic [15:0] d);
        @(negedge clock);
        drive(ce, cn, ud, sc, sl, d);
        for (int i = 0; i < 4; i++) st[i] = 0;
        model_push(ce, cn, ud, sc, sl, d);
        #1 aclr_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("async_clr_q", i, q_of(i), 16'h0);
        chk("async_clr_cout", 0, {12'h0, c_d, c_c, c_b, c_a}, 16'h0);
        #1 aclr_n = 1'b1;
    endtask

    // Monitor: sample combinational Cout just before the edge, Q and registered Cout after it.
    initial begin
        exp_t       e;
        logic [3:0] cpre, cpost;
        forever begin
            @(negedge clock);
            #4 cpre = {c_d, c_c, c_b, c_a};
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cpost = {c_d, c_c, c_b, c_a};
                for (int i = 0; i < 4; i++) begin
                    chk("q", i, q_of(i), e.q[i]);
`ifdef COUNTER_MOD_TC_REG_EN
                    chk("cout", i, {15'h0, cpost[i]}, {15'h0, e.ev[i]});
`else
                    chk("cout", i, {15'h0, cpre[i]}, {15'h0, e.ev[i]});
`endif
                end
            end
        end
    end

    initial begin
        aclr_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) st[i] = 0;
        #3;
        for (int i = 0; i < 4; i++) chk("reset_q", i, q_of(i), 16'h0);
        chk("reset_cout", 0, {12'h0, c_d, c_c, c_b, c_a}, 16'h0);
        repeat (2) @(posedge clock);
        #2;
        for (int i = 0; i < 4; i++) chk("reset_hold_q", i, q_of(i), 16'h0);
        chk("reset_hold_cout", 0, {12'h0, c_d, c_c, c_b, c_a}, 16'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        #2 aclr_n = 1'b1;

        // Up wrap through modulus 10, twelve counts.
        repeat (12) cyc(1, 1, 1, 0, 0, 16'h0);
        // Direction reversal from zero.
        cyc(1, 0, 1, 1, 0, 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 1, 0, 0, 16'h0);
        // Priority: clear over load over count, clamp, Clk_En hold.
        cyc(1, 0, 1, 0, 1, 16'h0005);
        cyc(1, 1, 1, 1, 1, 16'h0007);
        cyc(1, 0, 1, 0, 1, 16'h000C);
        cyc(0, 1, 1, 1, 1, 16'h0000);
        cyc(1, 0, 1, 0, 0, 16'h0000);
        // Load on the terminal edge suppresses wrap and Cout.
        cyc(1, 1, 1, 0, 1, 16'h0003);
        // Async clear while holding 6.
        cyc(1, 0, 1, 0, 1, 16'h0006);
        cyc_rst(1, 1, 1, 0, 0, 16'h0000);
        // Full-range wrap of the default instance.
        cyc(1, 0, 1, 0, 1, 16'hFFFE);
        repeat (3) cyc(1, 1, 1, 0, 0, 16'h0);
        repeat (3) cyc(1, 1, 0, 0, 0, 16'h0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic        ce, cn, ud, sc, sl;
            logic [15:0] d;
            ce = ($urandom_range(7) != 0);
            cn = ($urandom_range(3) != 0);
            ud = $urandom_range(1);
            sc = ($urandom_range(15) == 0);
            sl = ($urandom_range(7) == 0);
            d  = $urandom_range(1) ? 16'($urandom) : (16'hFFF0 | 16'($urandom_range(15)));
            if ($urandom_range(39) == 0) cyc_rst(ce, cn, ud, sc, sl, d);
            else                         cyc(ce, cn, ud, sc, sl, d);
        end

        @(posedge clock);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter lpm_width, default 16, Q/Data width in bits, legal range 2..32.
REQ-002 Parameter lpm_modulus, default 0, count range 0..lpm_modulus-1; 0 means 2^lpm_width.
REQ-003 Parameter lpm_direction, default "UNUSED": "UP" counts up, "DOWN" counts down, "UNUSED" lets the UpDown port select.
REQ-004 Port Clock, input, 1, sole clock, rising edge.
REQ-005 Port Aclr_n, input, 1, asynchronous active-low reset.
REQ-006 Port Clk_En, input, 1, global synchronous enable gating Sclr, Sload and counting.
REQ-007 Port Cnt_En, input, 1, count enable.
REQ-008 Port UpDown, input, 1, 1 = up, 0 = down; ignored unless lpm_direction = "UNUSED".
REQ-009 Port Sclr, input, 1, synchronous clear.
REQ-010 Port Sload, input, 1, synchronous load of Data.
REQ-011 Port Data, input, lpm_width, load value.
REQ-012 Port Q, output, lpm_width, count value.
REQ-013 Port Cout, output, 1, terminal-count / carry indication.

Function
REQ-014 Each rising Clock edge with Aclr_n = 1 and Clk_En = 1 SHALL apply this priority: Sclr > Sload > Cnt_En.
- Sclr: Q <= 0.
- Sload: Q <= Data, or lpm_modulus-1 if Data >= lpm_modulus.
- Cnt_En: Q <= next count.
REQ-015 Clk_En = 0 SHALL hold Q regardless of Sclr, Sload and Cnt_En.
REQ-016 Clk_En = 1 with Sclr, Sload and Cnt_En all 0 SHALL hold Q.
REQ-017 Up count SHALL step Q <= Q+1, wrapping lpm_modulus-1 -> 0.
REQ-018 Down count SHALL step Q <= Q-1, wrapping 0 -> lpm_modulus-1.
REQ-019 With lpm_modulus = 0, wrap SHALL occur at 2^lpm_width-1 <-> 0 with no overflow side effects.
REQ-020 The effective direction SHALL be sampled on the same edge as the count; a direction change takes effect on that edge with no idle cycle.
REQ-021 The terminal state SHALL be Q = lpm_modulus-1 when counting up and Q = 0 when counting down.
REQ-022 Count latency SHALL be one cycle: Q reflects an enabled count on the edge that samples Cnt_En.
REQ-023 Sclr or Sload asserted on the terminal edge SHALL suppress both the wrap and the Cout event.
REQ-024 Cout SHALL never assert while Aclr_n = 0.

Reset
REQ-025 Aclr_n = 0 SHALL immediately (asynchronously) force Q = 0 and Cout = 0, independent of Clock and Clk_En.
REQ-026 The first count after Aclr_n deasserts SHALL occur no earlier than the first rising edge on which Aclr_n is sampled 1.
REQ-027 Aclr_n asserted mid-count SHALL discard the count in flight, including any pending registered Cout.

Configuration
REQ-028 Macro COUNTER_MOD_TC_REG_EN SHALL select the Cout timing.
- Macro undefined: Cout is combinational: Cout = Clk_En & Cnt_En & ~Sclr & ~Sload & (Q at terminal state); it is high in the cycle before the wrap edge.
- Macro defined: Cout is a flop, set high for exactly one cycle starting at the edge where Q wraps; no combinational input-to-output path; one cycle later than the combinational form.
REQ-029 Q behaviour SHALL be identical with and without COUNTER_MOD_TC_REG_EN.

Verification
REQ-030 Up wrap: lpm_width=4, lpm_modulus=10, "UP", reset, then Cnt_En=1 for 12 cycles -> Q = 0,1,…,9,0,1,2; Cout high for exactly one cycle per wrap, at the timing selected by the macro.
REQ-031 UpDown reversal: "UNUSED", Q=0, UpDown=0 for 1 cycle -> Q=9; then UpDown=1 -> Q=0.
REQ-032 Priority: Q=5, Sclr=1, Sload=1, Data=7, Cnt_En=1 -> Q=0; then Sload=1, Data=12 -> Q=9 (clamped); then Clk_En=0 with Sclr=1 -> Q stays 9.
REQ-033 Async reset: Aclr_n pulsed low between edges while Q=6 -> Q=0 before the next edge; Cout=0.
REQ-034 Default parameters (16-bit, modulus 0): Sload Data=16'hFFFE, count up 3 -> Q = FFFF, 0000, 0001; one Cout per wrap.
REQ-035 Terminal suppression: Q=9 up, Sload=1, Data=3 -> Q=3; no Cout in either macro build.
